// File: rtl/spram_arb_pkg.sv
// Shared types and constants for the spram arbiter slice.
package spram_arb_pkg;

    // Width of the consecutive-video-grant counter
    localparam int unsigned CNT_W = 4;

    // Requester identity carried by the read-return tag
    typedef enum logic {
        PORT_VID = 1'b0,
        PORT_CPU = 1'b1
    } port_e;

    // Read-return tag: one read may be in flight per cycle
    typedef struct packed {
        logic  valid;
        port_e port;
    } tag_t;

endpackage : spram_arb_pkg

// File: rtl/spram_arb_if.sv
// Bus bundle between requesters, the arbiter and the single-port RAM.
interface spram_arb_if #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 32
);

    // Video read port
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_ack;
    logic          vid_rvalid;
    logic [DW-1:0] vid_rdata;

    // CPU read/write port
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;

    // RAM side
    logic          ram_ce;
    logic          ram_we;
    logic          ram_oe;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_di;
    logic [DW-1:0] ram_do;

    // Requesters drive requests and consume acks/read data
    modport master (
        output vid_req, vid_addr,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  vid_ack, vid_rvalid, vid_rdata,
        input  cpu_ack, cpu_rvalid, cpu_rdata
    );

    // Arbiter: serves both requesters and drives the RAM
    modport slave (
        input  vid_req, vid_addr,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output vid_ack, vid_rvalid, vid_rdata,
        output cpu_ack, cpu_rvalid, cpu_rdata,
        output ram_ce, ram_we, ram_oe, ram_addr, ram_di,
        input  ram_do
    );

    // RAM view of the bundle
    modport mem (
        input  ram_ce, ram_we, ram_oe, ram_addr, ram_di,
        output ram_do
    );

endinterface : spram_arb_if

// File: rtl/spram.sv
// Single-port synchronous RAM: one access per cycle, registered read data.
module spram #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          ce,
    input  logic          we,
    input  logic          oe,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] di,
    output logic [DW-1:0] dout
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    // Write on ce&we; read data appears the cycle after ce&oe and holds otherwise
    always_ff @(posedge clk) begin
        if (ce && we) begin
            mem[addr] <= di;
        end
        if (ce && oe) begin
            dout <= mem[addr];
        end
    end

endmodule : spram

// File: rtl/spram_arb.sv
// Two-port front end time-sharing one spram between video reads and CPU accesses.
module spram_arb
    import spram_arb_pkg::*;
#(
    parameter int unsigned AW      = 10,
    parameter int unsigned DW      = 32,
    parameter int unsigned MAX_VID = 4
) (
    input  logic        clk,
    input  logic        rst,
    spram_arb_if.slave  bus
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_VID);

    logic             rst_q;
    logic             blocked;
    logic             vid_win;
    logic             vid_gnt;
    logic             cpu_gnt;
    logic [CNT_W-1:0] vid_cnt;
    logic [CNT_W-1:0] vid_cnt_d;
    tag_t             tag_q;
    tag_t             tag_d;
    logic             vid_hit;
    logic             cpu_hit;
    logic [DW-1:0]    vid_rdata_q;
    logic [DW-1:0]    cpu_rdata_q;
    logic [DW-1:0]    vid_rdata_c;
    logic [DW-1:0]    cpu_rdata_c;

    // Grant decision: video first, unless it has already won MAX_VID times over a waiting CPU
    always_comb begin
        blocked = rst | rst_q;
        vid_win = bus.vid_req & (~bus.cpu_req | (vid_cnt < MAX_CNT));
        vid_gnt = ~blocked & vid_win;
        cpu_gnt = ~blocked & bus.cpu_req & ~vid_win;
    end

    // Starvation counter: counts video wins over a pending CPU, cleared when the CPU is served or idle
    always_comb begin
        vid_cnt_d = vid_cnt;
        if (!bus.cpu_req || cpu_gnt) begin
            vid_cnt_d = '0;
        end else if (vid_gnt && (vid_cnt < MAX_CNT)) begin
            vid_cnt_d = vid_cnt + CNT_W'(1);
        end
    end

    // RAM drive for the granted access; everything low when nothing is granted
    always_comb begin
        bus.ram_ce   = 1'b0;
        bus.ram_we   = 1'b0;
        bus.ram_oe   = 1'b0;
        bus.ram_addr = '0;
        bus.ram_di   = '0;
        if (vid_gnt) begin
            bus.ram_ce   = 1'b1;
            bus.ram_oe   = 1'b1;
            bus.ram_addr = bus.vid_addr;
        end else if (cpu_gnt) begin
            bus.ram_ce   = 1'b1;
            bus.ram_addr = bus.cpu_addr;
            if (bus.cpu_we) begin
                bus.ram_we = 1'b1;
                bus.ram_di = bus.cpu_wdata;
            end else begin
                bus.ram_oe = 1'b1;
            end
        end
    end

    // Tag each read grant so the returning data is steered to its requester
    always_comb begin
        tag_d.valid = vid_gnt | (cpu_gnt & ~bus.cpu_we);
        tag_d.port  = cpu_gnt ? PORT_CPU : PORT_VID;
    end

    // Read return: ram_do is only meaningful on a tagged cycle, otherwise each port holds its last data
    always_comb begin
        vid_hit     = ~rst & tag_q.valid & (tag_q.port == PORT_VID);
        cpu_hit     = ~rst & tag_q.valid & (tag_q.port == PORT_CPU);
        vid_rdata_c = vid_rdata_q;
        cpu_rdata_c = cpu_rdata_q;
        if (rst) begin
            vid_rdata_c = '0;
            cpu_rdata_c = '0;
        end else begin
            if (vid_hit) begin
                vid_rdata_c = bus.ram_do;
            end
            if (cpu_hit) begin
                cpu_rdata_c = bus.ram_do;
            end
        end
    end

    assign bus.vid_ack    = vid_gnt;
    assign bus.cpu_ack    = cpu_gnt;
    assign bus.vid_rvalid = vid_hit;
    assign bus.cpu_rvalid = cpu_hit;
    assign bus.vid_rdata  = vid_rdata_c;
    assign bus.cpu_rdata  = cpu_rdata_c;

    // State registers; reset drops any in-flight read and blocks grants for one extra cycle
    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            vid_cnt     <= '0;
            tag_q       <= '0;
            vid_rdata_q <= '0;
            cpu_rdata_q <= '0;
        end else begin
            vid_cnt     <= vid_cnt_d;
            tag_q       <= tag_d;
            vid_rdata_q <= vid_rdata_c;
            cpu_rdata_q <= cpu_rdata_c;
        end
    end

endmodule : spram_arb
